// File: rtl/gfx_irq_ctrl_if.sv
// Register request/response port of gfx_irq_ctrl.
// Latency: response one cycle after the accepting edge.
// Backpressure: none; the slave always accepts (reg_ready tied high).
//
// Signals:
//   reg_valid/reg_write/reg_addr/reg_wdata : request, master -> slave
//   reg_ready                              : accept, slave -> master
//   rsp_valid/rsp_rdata/rsp_err            : registered response, slave -> master
interface gfx_irq_ctrl_if;
  logic        reg_valid;
  logic        reg_ready;
  logic        reg_write;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output reg_valid,
    output reg_write,
    output reg_addr,
    output reg_wdata,
    input  reg_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  reg_valid,
    input  reg_write,
    input  reg_addr,
    input  reg_wdata,
    output reg_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/gfx_irq_ctrl.sv
// Interrupt aggregator: NUM_SRC level/edge sources -> pending -> mask -> route onto NUM_OUT irq lines.
// Latency: src to irq 2 cycles (4 with GFX_IRQ_CTRL_SYNC_EN); register response 1 cycle after request.
// Backpressure: none; every register request is accepted in the cycle it is presented.
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   src      : raw interrupt inputs, one bit per source
//   bus      : gfx_irq_ctrl_if.slave register port (request / registered response)
//   irq      : registered irq lines toward the scheduler
//
// Optional build macro: GFX_IRQ_CTRL_SYNC_EN -- adds a 2-flop synchroniser on each src bit.
//
// Register map (word address):
//   0x00 PENDING (RO)  0x01 CLEAR (W1C, reads 0)  0x02 MASK (RW, 1 = enabled)
//   0x03 MODE (RW, 1 = edge)  0x04 RAW (RO, qualified src)  0x10+i ROUTE[i] (RW)
//   anything else: rsp_err = 1, read data 0, write dropped.
module gfx_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int NUM_OUT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  gfx_irq_ctrl_if.slave      bus,
  output logic [NUM_OUT-1:0] irq
);

  localparam int OUT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  // One extra route bit so that a selection beyond the last line survives
  // readback unchanged; such a value simply never matches any line.
  localparam int RTE_W = OUT_W + 1;

  localparam logic [4:0] A_PENDING = 5'h00;
  localparam logic [4:0] A_CLEAR   = 5'h01;
  localparam logic [4:0] A_MASK    = 5'h02;
  localparam logic [4:0] A_MODE    = 5'h03;
  localparam logic [4:0] A_RAW     = 5'h04;

  // ------------------------------------------------------------------
  // Source qualification
  // ------------------------------------------------------------------
  logic [NUM_SRC-1:0] q;

`ifdef GFX_IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1_d, sync1_q;
  logic [NUM_SRC-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = src;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q = sync2_q;
`else
  // Sources are synchronous to clk in this build.
  assign q = src;
`endif

  // ------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------
  logic [NUM_SRC-1:0] mask_d,    mask_q;
  logic [NUM_SRC-1:0] mode_d,    mode_q;
  logic [NUM_SRC-1:0] pending_d, pending_q;
  logic [NUM_SRC-1:0] q_d_d,     q_d_q;
  logic [RTE_W-1:0]   route_d [NUM_SRC];
  logic [RTE_W-1:0]   route_q [NUM_SRC];
  logic [NUM_OUT-1:0] irq_d,     irq_q;
  logic               rsp_valid_d, rsp_valid_q;
  logic [31:0]        rsp_rdata_d, rsp_rdata_q;
  logic               rsp_err_d,   rsp_err_q;

  // ------------------------------------------------------------------
  // Address decode
  // ------------------------------------------------------------------
  logic               sel_pending;
  logic               sel_clear;
  logic               sel_mask;
  logic               sel_mode;
  logic               sel_raw;
  logic [NUM_SRC-1:0] sel_route;
  logic               addr_hit;
  logic               wr_en;
  logic               rd_en;

  always_comb begin
    sel_pending = (bus.reg_addr == A_PENDING);
    sel_clear   = (bus.reg_addr == A_CLEAR);
    sel_mask    = (bus.reg_addr == A_MASK);
    sel_mode    = (bus.reg_addr == A_MODE);
    sel_raw     = (bus.reg_addr == A_RAW);
    sel_route   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_route[i] = (bus.reg_addr == 5'(16 + i));
    end
    addr_hit = sel_pending | sel_clear | sel_mask | sel_mode | sel_raw | (|sel_route);
    // Unmapped writes are dropped simply because no select matches.
    wr_en = bus.reg_valid & bus.reg_write;
    rd_en = bus.reg_valid & ~bus.reg_write;
  end

  // Only the low NUM_SRC bits of write data carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^bus.reg_wdata[31:NUM_SRC];

  // ------------------------------------------------------------------
  // Configuration registers: writes land on the accepting edge
  // ------------------------------------------------------------------
  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    route_d = route_q;
    if (wr_en && sel_mask) begin
      mask_d = bus.reg_wdata[NUM_SRC-1:0];
    end
    if (wr_en && sel_mode) begin
      mode_d = bus.reg_wdata[NUM_SRC-1:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr_en && sel_route[i]) begin
        route_d[i] = bus.reg_wdata[RTE_W-1:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // Pending bits
  // ------------------------------------------------------------------
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_vec;

  always_comb begin
    rise    = q & ~q_d_q;
    clr_vec = (wr_en && sel_clear) ? bus.reg_wdata[NUM_SRC-1:0] : '0;
    // History always follows q, so a level->edge switch of a high source
    // does not look like a fresh edge.
    q_d_d   = q;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode_q[i]) begin
        // Edge: sticky until cleared; a same-cycle edge beats the clear.
        pending_d[i] = rise[i] | (pending_q[i] & ~clr_vec[i]);
      end else begin
        // Level: pending mirrors the source; CLEAR is meaningless here.
        pending_d[i] = q[i];
      end
    end
  end

  // ------------------------------------------------------------------
  // Output routing: an irq line ORs every enabled pending source routed to it
  // ------------------------------------------------------------------
  always_comb begin
    irq_d = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pending_q[i] && mask_q[i] && (route_q[i] == RTE_W'(k))) begin
          irq_d[k] = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Register response: reads see state before the accepting edge
  // ------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = bus.reg_valid;
    rsp_err_d   = bus.reg_valid & ~addr_hit;
    rsp_rdata_d = '0;
    if (rd_en) begin
      if (sel_pending) begin
        rsp_rdata_d[NUM_SRC-1:0] = pending_q;
      end
      if (sel_mask) begin
        rsp_rdata_d[NUM_SRC-1:0] = mask_q;
      end
      if (sel_mode) begin
        rsp_rdata_d[NUM_SRC-1:0] = mode_q;
      end
      if (sel_raw) begin
        rsp_rdata_d[NUM_SRC-1:0] = q;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel_route[i]) begin
          rsp_rdata_d[RTE_W-1:0] = route_q[i];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Flops
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q      <= '0;
      mode_q      <= '0;
      pending_q   <= '0;
      q_d_q       <= '0;
      route_q     <= '{default: '0};
      irq_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      q_d_q       <= q_d_d;
      route_q     <= route_d;
      irq_q       <= irq_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.reg_ready = 1'b1;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gfx_irq_ctrl.sv
// Directed bench for gfx_irq_ctrl: register responses are scoreboarded,
// irq lines are checked inline after each stimulus step.
module tb_gfx_irq_ctrl;

  localparam int NS = 8;
  localparam int NO = 4;
`ifdef GFX_IRQ_CTRL_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = 2 + SYNC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NS-1:0] src = '0;
  logic [NO-1:0] irq;

  gfx_irq_ctrl_if bus ();

  gfx_irq_ctrl #(.NUM_SRC(NS), .NUM_OUT(NO)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one request for one cycle and queue its expected response.
  task automatic req(string tag, logic w, logic [4:0] a, logic [31:0] d,
                     logic [31:0] er, logic ee);
    exp_t e;
    bus.reg_valid = 1'b1;
    bus.reg_write = w;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    e.tag   = tag;
    e.rdata = er;
    e.err   = ee;
    e.cyc   = cyc + 1;
    sb.push_back(e);
    tick();
    bus.reg_valid = 1'b0;
    bus.reg_write = 1'b0;
  endtask

  task automatic rd(string tag, logic [4:0] a, logic [31:0] er);
    req(tag, 1'b0, a, 32'h0, er, 1'b0);
  endtask

  task automatic wr(string tag, logic [4:0] a, logic [31:0] d);
    req(tag, 1'b1, a, d, 32'h0, 1'b0);
  endtask

  // Response monitor: pops the scoreboard on every response strobe.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected: observed response rdata=%0h with nothing queued", bus.rsp_rdata);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
        chk({e.tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
        chk({e.tag, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.reg_valid = 1'b0;
    bus.reg_write = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;

    // Reset state
    tick(3);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_ready", 32'(bus.reg_ready), 32'h1);
    rst = 1'b0;
    tick();
    rd("rst_pending", 5'h00, 32'h0);
    rd("rst_mask",    5'h02, 32'h0);
    rd("rst_mode",    5'h03, 32'h0);
    rd("rst_route0",  5'h10, 32'h0);
    src = 8'hFF;
    tick(LAT + 1);
    chk("masked_irq", 32'(irq), 32'h0);
    rd("level_all_pending", 5'h00, 32'hFF);
    src = 8'h00;
    tick(LAT);

    // Level path
    wr("lvl_mask",   5'h02, 32'h01);
    wr("lvl_route0", 5'h10, 32'h2);
    src[0] = 1'b1;
    tick(LAT - 1);
    chk("lvl_irq_early", 32'(irq), 32'h0);
    tick();
    chk("lvl_irq_high", 32'(irq), 32'h4);
    wr("lvl_clear", 5'h01, 32'h01);
    tick();
    chk("lvl_clear_no_effect", 32'(irq), 32'h4);
    rd("lvl_pending", 5'h00, 32'h01);
    src[0] = 1'b0;
    tick(LAT - 1);
    chk("lvl_drop_early", 32'(irq), 32'h4);
    tick();
    chk("lvl_drop_low", 32'(irq), 32'h0);

    // Edge latch and clear
    wr("edge_mode",   5'h03, 32'h02);
    wr("edge_mask",   5'h02, 32'h02);
    wr("edge_route1", 5'h11, 32'h1);
    src[1] = 1'b1;
    tick();
    src[1] = 1'b0;
    tick(LAT - 2);
    chk("edge_irq_early", 32'(irq), 32'h0);
    tick();
    chk("edge_irq_high", 32'(irq), 32'h2);
    tick(3);
    chk("edge_irq_sticky", 32'(irq), 32'h2);
    rd("edge_pending", 5'h00, 32'h02);
    wr("edge_clear", 5'h01, 32'h02);
    chk("edge_clr_irq_hold", 32'(irq), 32'h2);
    tick();
    chk("edge_clr_irq_low", 32'(irq), 32'h0);
    rd("edge_pending_cleared", 5'h00, 32'h0);

    // Set/clear collision: the edge wins
    src[1] = 1'b1;
    tick();
    src[1] = 1'b0;
    tick(LAT);
    chk("coll_pre_irq", 32'(irq), 32'h2);
    src[1] = 1'b1;
    tick(SYNC);
    wr("coll_clear", 5'h01, 32'h02);
    rd("coll_pending", 5'h00, 32'h02);
    tick();
    chk("coll_irq", 32'(irq), 32'h2);
    src[1] = 1'b0;
    wr("coll_clear2", 5'h01, 32'h02);
    tick();
    chk("coll_irq_cleared", 32'(irq), 32'h0);

    // Routing fan-in and out-of-range route
    wr("rt_mode",   5'h03, 32'h0);
    wr("rt_mask",   5'h02, 32'h09);
    wr("rt_route0", 5'h10, 32'h3);
    wr("rt_route3", 5'h13, 32'h3);
    src = 8'h08;
    tick(LAT);
    chk("rt_src3_irq", 32'(irq), 32'h8);
    src = 8'h01;
    tick(LAT);
    chk("rt_src0_irq", 32'(irq), 32'h8);
    src = 8'h08;
    tick(LAT);
    wr("rt_bad_route", 5'h13, 32'h7);
    tick();
    chk("rt_bad_irq", 32'(irq), 32'h0);
    rd("rt_bad_readback", 5'h13, 32'h7);
    rd("raw", 5'h04, 32'h08);

    // Bus errors and ignored accesses
    req("err_rd05", 1'b0, 5'h05, 32'h0, 32'h0, 1'b1);
    req("err_wr1f", 1'b1, 5'h1F, 32'hFFFF_FFFF, 32'h0, 1'b1);
    req("err_rd18", 1'b0, 5'h18, 32'h0, 32'h0, 1'b1);
    wr("wr_pending_ignored", 5'h00, 32'hFF);
    rd("pending_after_wr", 5'h00, 32'h08);
    rd("clear_reads_zero", 5'h01, 32'h0);

    // Write then immediate read; bits above NUM_SRC dropped
    wr("mask_all", 5'h02, 32'hFFFF_FFFF);
    rd("mask_all_rd", 5'h02, 32'hFF);
    wr("mask_back", 5'h02, 32'h09);

    // Back-to-back reads
    rd("b2b_mask",   5'h02, 32'h09);
    rd("b2b_mode",   5'h03, 32'h0);
    rd("b2b_route0", 5'h10, 32'h3);
    rd("b2b_route3", 5'h13, 32'h7);

    // Reset mid-operation drops the in-flight response
    wr("pre_rst_route3", 5'h13, 32'h3);
    tick(2);
    chk("pre_rst_irq", 32'(irq), 32'h8);
    bus.reg_valid = 1'b1;
    bus.reg_write = 1'b0;
    bus.reg_addr  = 5'h02;
    tick();
    bus.reg_valid = 1'b0;
    chk("pre_rst_rsp", 32'(bus.rsp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    tick(2);
    rst = 1'b0;
    src = 8'h00;
    tick();
    rd("post_rst_mask",   5'h02, 32'h0);
    rd("post_rst_route3", 5'h13, 32'h0);
    tick(3);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d outstanding responses, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
